pipelined_ks_addsub: RTL and testbench
======================================

PIPELINED_KS_ADDSUB -- requirements
Module: pipelined_ks_addsub

Interface
REQ-001 Parameter WIDTH, default 32, operand width; SHALL be a power of two in 8..64.
REQ-002 Derived constant LVL = log2(WIDTH) SHALL be the prefix level count; LAT = LVL+1 SHALL be the pipeline latency.
REQ-003 clk  in  1  sole clock; all state SHALL update on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  operand beat present.
REQ-006 in_ready  out  1  block accepts beat this cycle.
REQ-007 a  in  WIDTH  operand A.
REQ-008 b  in  WIDTH  operand B.
REQ-009 cin  in  1  carry-in, add mode only.
REQ-010 sub  in  1  1 = subtract (a - b), 0 = add (a + b + cin).
REQ-011 out_valid  out  1  result beat present.
REQ-012 out_ready  in  1  downstream accepts result.
REQ-013 sum  out  WIDTH  result.
REQ-014 cout  out  1  carry out of MSB.
REQ-015 ovf  out  1  two's-complement signed overflow.

Function
REQ-016 Stage 0 SHALL register bitwise G = a&b', P = a^b', where b' = sub ? ~b : b, plus c0 = sub ? 1 : cin, plus valid bit.
REQ-017 Each prefix level k (1..LVL) SHALL combine span 2^(k-1) Kogge-Stone style (black cells where index >= 2^(k-1), buffers below) and register its G/P and valid.
REQ-018 Carry into bit i SHALL be c0 for i=0 and final group G[i-1] (including c0) for i>0; sum[i] = P[i] ^ carry[i].
REQ-019 cout SHALL equal carry out of bit WIDTH-1; ovf SHALL equal carry into MSB XOR cout.
REQ-020 sum/cout/ovf SHALL be registered at level LVL output; accepted beat at edge n SHALL appear with out_valid=1 after edge n+LAT.
REQ-021 Pipeline SHALL advance as a single unit: advance = ~out_valid | out_ready.
REQ-022 in_ready SHALL equal advance, combinationally; beat accepted when in_valid & in_ready at a rising edge.
REQ-023 When advance=0, every stage register, including data, SHALL hold value.
REQ-024 Bubbles (in_valid=0 on advance) SHALL propagate as valid=0 stages; no bubble collapsing.
REQ-025 sum, cout, ovf SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 Simultaneous output consume and input accept SHALL sustain one result per cycle throughput.
REQ-027 Arithmetic SHALL wrap modulo 2^WIDTH; no width extension.

Reset
REQ-028 rst=1 SHALL immediately clear all stage valid bits and out_valid; sum, cout, ovf SHALL read 0.
REQ-029 Reset mid-operation SHALL discard all in-flight beats; no result for them SHALL ever emerge.
REQ-030 First beat accepted after rst deasserts SHALL emerge exactly LAT edges later.

Configuration
REQ-031 Macro KS_ADDSUB_SAT_EN SHALL, when defined, clamp sum on ovf=1 to 0x7F..F (operands positive) or 0x80..0 (negative); ovf still reports overflow, cout unchanged.
REQ-032 Without KS_ADDSUB_SAT_EN, sum SHALL be the wrapped result and no clamp logic SHALL exist.

Verification (WIDTH=32, LAT=6)
REQ-033 a=0x0000_0001, b=0xFFFF_FFFF, cin=0, sub=0 -> after 6 edges sum=0, cout=1, ovf=0.
REQ-034 a=0x7FFF_FFFF, b=1, sub=0 -> ovf=1; sum=0x8000_0000 (no macro) or 0x7FFF_FFFF (KS_ADDSUB_SAT_EN).
REQ-035 a=5, b=7, sub=1 -> sum=0xFFFF_FFFE, cout=0, ovf=0.
REQ-036 Back-to-back 100 random beats, out_ready=1 -> one result per cycle, matches a+b+cin / a-b reference model.
REQ-037 out_ready held 0 for 10 cycles with pipeline full -> in_ready=0, outputs stable, no beat lost or duplicated after release.
REQ-038 rst pulsed with 3 beats in flight -> out_valid=0 immediately, those beats never emitted, next beat emerges after 6 edges.

Source files
------------

// File: rtl/pipelined_ks_addsub_if.sv
// pipelined_ks_addsub_if: operand/result valid-ready bundle for the Kogge-Stone adder/subtractor.
interface pipelined_ks_addsub_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf);
  modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, sum, cout, ovf);
endinterface

// File: rtl/pipelined_ks_addsub.sv
// pipelined_ks_addsub: Kogge-Stone add/sub, one register per prefix level, latency log2(WIDTH)+1.
// Define KS_ADDSUB_SAT_EN to saturate sum on signed overflow.
module pipelined_ks_addsub #(
  parameter int WIDTH = 32
) (
  input logic                   clk,
  input logic                   rst,
  pipelined_ks_addsub_if.slave  io
);
  localparam int LVL = $clog2(WIDTH);
  logic [WIDTH-1:0] g_q [LVL+1];
  logic [WIDTH-1:0] g_d [LVL+1];
  logic [WIDTH-1:0] p_q [LVL+1];
  logic [WIDTH-1:0] p_d [LVL+1];
  logic [WIDTH-1:0] x_q [LVL+1];
  logic [WIDTH-1:0] x_d [LVL+1];
  logic [LVL:0]     c0_q, c0_d, v_q, v_d;
  logic [WIDTH-1:0] sum_q, sum_d, bb, carry, raw;
  logic             cout_q, cout_d, ovf_q, ovf_d, out_valid_q, out_valid_d, adv;
  assign adv          = ~out_valid_q | io.out_ready;
  assign io.in_ready  = adv;
  assign io.out_valid = out_valid_q;
  assign io.sum       = sum_q;
  assign io.cout      = cout_q;
  assign io.ovf       = ovf_q;
  always_comb begin
    bb      = io.sub ? ~io.b : io.b;
    g_d[0]  = io.a & bb;
    p_d[0]  = io.a ^ bb;
    x_d[0]  = io.a ^ bb;
    c0_d[0] = io.sub | io.cin;
    v_d[0]  = io.in_valid;
    for (int k = 1; k <= LVL; k++) begin
      g_d[k]  = g_q[k-1];
      p_d[k]  = p_q[k-1];
      x_d[k]  = x_q[k-1];
      c0_d[k] = c0_q[k-1];
      v_d[k]  = v_q[k-1];
      for (int i = 1 << (k - 1); i < WIDTH; i++) begin
        g_d[k][i] = g_q[k-1][i] | (p_q[k-1][i] & g_q[k-1][i-(1<<(k-1))]);
        p_d[k][i] = p_q[k-1][i] & p_q[k-1][i-(1<<(k-1))];
      end
    end
    // c0 folds into every prefix group here rather than entering the tree as bit -1
    carry  = {g_q[LVL][WIDTH-2:0] | (p_q[LVL][WIDTH-2:0] & {(WIDTH-1){c0_q[LVL]}}), c0_q[LVL]};
    cout_d = g_q[LVL][WIDTH-1] | (p_q[LVL][WIDTH-1] & c0_q[LVL]);
    ovf_d  = carry[WIDTH-1] ^ cout_d;
    raw    = x_q[LVL] ^ carry;
`ifdef KS_ADDSUB_SAT_EN
    // overflow flips the sign, so the operands' common sign is the inverse of raw's MSB
    sum_d  = ovf_d ? {~raw[WIDTH-1], {(WIDTH-1){raw[WIDTH-1]}}} : raw;
`else
    sum_d  = raw;
`endif
    out_valid_d = v_q[LVL];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= LVL; k++) begin
        g_q[k] <= '0;
        p_q[k] <= '0;
        x_q[k] <= '0;
      end
      c0_q        <= '0;
      v_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (adv) begin
      g_q         <= g_d;
      p_q         <= p_d;
      x_q         <= x_d;
      c0_q        <= c0_d;
      v_q         <= v_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_pipelined_ks_addsub.sv
// tb_pipelined_ks_addsub: random and directed beats scored against an arithmetic reference model.
module tb_pipelined_ks_addsub;
  localparam int W   = 32;
  localparam int LAT = $clog2(W) + 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pipelined_ks_addsub_if #(.WIDTH(W)) ifc ();
  pipelined_ks_addsub #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .io(ifc));
  int n_cmp = 0, n_err = 0, cyc = 0, n_emit = 0, n_acc = 0;
  bit chk_lat = 1'b0;
  logic [W+1:0] q[$];
  int tq[$];
  logic [W+1:0] last_res, snap;
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, b, input logic ci, sb);
    logic [W:0] full;
    logic [W-1:0] s;
    logic co, ov;
    if (sb) begin
      s  = a - b;
      co = a >= b;
      ov = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
    end else begin
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      s    = full[W-1:0];
      co   = full[W];
      ov   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    end
`ifdef KS_ADDSUB_SAT_EN
    if (ov) s = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return {co, ov, s};
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic drive(input logic v, input logic [W-1:0] a, b, input logic ci, sb);
    ifc.in_valid = v;
    ifc.a        = a;
    ifc.b        = b;
    ifc.cin      = ci;
    ifc.sub      = sb;
  endtask
  task automatic drive_rand();
    logic [W-1:0] a, b;
    a = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
    b = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
    drive(1'b1, a, b, 1'($urandom), 1'($urandom));
  endtask
  task automatic step();
    logic [W+1:0] e;
    int t;
    @(negedge clk);
    if (ifc.out_valid && ifc.out_ready) begin
      n_emit++;
      last_res = {ifc.cout, ifc.ovf, ifc.sum};
      check("result_expected", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        t = tq.pop_front();
        check("res", 64'(last_res), 64'(e));
        if (chk_lat) check("lat", 64'(cyc - t), 64'(LAT));
      end
    end
    if (ifc.in_valid && ifc.in_ready) begin
      n_acc++;
      q.push_back(ref_model(ifc.a, ifc.b, ifc.cin, ifc.sub));
      tq.push_back(cyc + 1);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask
  task automatic send_one(input logic [W-1:0] a, b, input logic ci, sb,
                          input logic [W+1:0] exp, input string tag);
    int e0;
    e0 = n_emit;
    drive(1'b1, a, b, ci, sb);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3 * LAT && n_emit == e0; i++) step();
    if (n_emit == e0) check({tag, "_timeout"}, 64'(n_emit - e0), 64'd1);
    else check(tag, 64'(last_res), 64'(exp));
  endtask
  initial begin
    int e0, a0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    ifc.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(ifc.out_valid), 64'd0);
    check("rst_sum", 64'(ifc.sum), 64'd0);
    check("rst_cout", 64'(ifc.cout), 64'd0);
    check("rst_ovf", 64'(ifc.ovf), 64'd0);
    check("rst_in_ready", 64'(ifc.in_ready), 64'd1);
    rst = 1'b0;
    chk_lat = 1'b1;
    send_one(32'h1, 32'hFFFF_FFFF, 1'b0, 1'b0, {1'b1, 1'b0, 32'h0}, "add_wrap");
`ifdef KS_ADDSUB_SAT_EN
    send_one(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, {1'b0, 1'b1, 32'h7FFF_FFFF}, "add_ovf");
    send_one(32'h8000_0000, 32'h1, 1'b0, 1'b1, {1'b1, 1'b1, 32'h8000_0000}, "sub_ovf");
`else
    send_one(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, {1'b0, 1'b1, 32'h8000_0000}, "add_ovf");
    send_one(32'h8000_0000, 32'h1, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF}, "sub_ovf");
`endif
    send_one(32'h5, 32'h7, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE}, "sub_neg");
    send_one(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, {1'b1, 1'b0, 32'h0}, "add_cin");
    send_one(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b1, {1'b1, 1'b0, 32'h0}, "sub_eq_ignores_cin");
    e0 = n_emit;
    a0 = n_acc;
    for (int i = 0; i < 100; i++) begin
      drive_rand();
      step();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (LAT + 1) step();
    check("b2b_accepted", 64'(n_acc - a0), 64'd100);
    check("b2b_emitted", 64'(n_emit - e0), 64'd100);
    chk_lat = 1'b0;
    ifc.out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive_rand();
      step();
    end
    check("stall_in_ready", 64'(ifc.in_ready), 64'd0);
    check("stall_out_valid", 64'(ifc.out_valid), 64'd1);
    snap = {ifc.cout, ifc.ovf, ifc.sum};
    for (int i = 0; i < 10; i++) begin
      drive_rand();
      step();
      check("stall_hold", 64'({ifc.cout, ifc.ovf, ifc.sum}), 64'(snap));
      check("stall_in_ready_hold", 64'(ifc.in_ready), 64'd0);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() > 0; i++) step();
    check("stall_drain", 64'(q.size()), 64'd0);
    repeat (5) step();
    chk_lat = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      step();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(ifc.out_valid), 64'd0);
    check("midrst_sum", 64'(ifc.sum), 64'd0);
    q.delete();
    tq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_in_ready", 64'(ifc.in_ready), 64'd1);
    send_one(32'h0000_1234, 32'h0000_1111, 1'b1, 1'b0, {1'b0, 1'b0, 32'h0000_2346}, "post_rst");
    repeat (15) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
